lcd_sum_display: RTL and testbench



---
 rtl/lcd_sum_pkg.sv | 64 ++++++
 rtl/lcd_nibble_tx.sv | 80 ++++++++
 rtl/lcd_sum_display.sv | 249 ++++++++++++++++++++++++
 tb/tb_lcd_sum_display.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_sum_pkg.sv
// Shared types and constants for the LCD sum display: FSM states, nibble phases,
// LCD command bytes, ASCII codes and a digit-count helper.
package lcd_sum_pkg;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_IDLE,
      ST_CONVERT,
      ST_HOME,
      ST_WRITE
   } state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } phase_e;

   localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
   localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
   localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_HOME       = 8'h80;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   // four wake-up nibbles followed by four command bytes
   localparam int INIT_NIBBLES = 12;

   function automatic int digit_count(input int bits);
      int v;
      int n;
      v = (1 << bits) - 1;
      n = 1;
      v = v / 10;
      while (v > 0) begin
         n++;
         v = v / 10;
      end
      return n;
   endfunction

   function automatic logic [3:0] init_nibble(input logic [4:0] idx);
      logic [3:0] n;
      case (idx)
         5'd0, 5'd1, 5'd2: n = 4'h3;
         5'd3:  n = 4'h2;
         5'd4:  n = CMD_FUNC_SET[7:4];
         5'd5:  n = CMD_FUNC_SET[3:0];
         5'd6:  n = CMD_ENTRY_MODE[7:4];
         5'd7:  n = CMD_ENTRY_MODE[3:0];
         5'd8:  n = CMD_DISP_ON[7:4];
         5'd9:  n = CMD_DISP_ON[3:0];
         5'd10: n = CMD_CLEAR[7:4];
         5'd11: n = CMD_CLEAR[3:0];
         default: n = 4'h0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Three-phase LCD nibble transmitter (setup / enable pulse / hold), each phase
// STEP_CYCLES long; ack is high on the final hold cycle.
module lcd_nibble_tx
   import lcd_sum_pkg::*;
#(
   parameter int STEP_CYCLES = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] nib,
   input  logic       rs,
   output logic       ack,
   output logic       lcd_e,
   output logic [3:0] lcd_d,
   output logic       lcd_rs
);

   localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);

   phase_e      phase_q, phase_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  data_q, data_d;
   logic        rs_q, rs_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         rs_q    <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      rs_d    = rs_q;
      ack     = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (load) begin
               phase_d = PH_SETUP;
               cnt_d   = STEP_LAST;
               data_d  = nib;
               rs_d    = rs;
            end
         end
         PH_SETUP, PH_PULSE: begin
            if (cnt_q == 16'd0) begin
               phase_d = (phase_q == PH_SETUP) ? PH_PULSE : PH_HOLD;
               cnt_d   = STEP_LAST;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         PH_HOLD: begin
            if (cnt_q == 16'd0) begin
               phase_d = PH_IDLE;
               ack     = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: phase_d = PH_IDLE;
      endcase
   end

   // data and rs stay latched after the transfer so the bus never glitches
   assign lcd_e  = (phase_q == PH_PULSE);
   assign lcd_d  = data_q;
   assign lcd_rs = rs_q;

endmodule

// File: rtl/lcd_sum_display.sv
// Adds two operands, converts the sum to BCD and draws it on a 4-bit LCD.
// Optional macro LCD_SUM_AUTO_REFRESH_EN adds a periodic redraw from IDLE.
//
// state      | meaning
// PWR_WAIT   | power-up delay after reset
// INIT       | wake-up nibbles, setup commands, clear delay
// IDLE       | waiting for start (busy low)
// CONVERT    | shift-add-3 binary to BCD, one bit per cycle
// HOME       | cursor home command
// WRITE      | send decimal characters, MS digit first
module lcd_sum_display
   import lcd_sum_pkg::*;
#(
   parameter int WIDTH          = 4,
   parameter int STEP_CYCLES    = 50,
   parameter int POWERUP_CYCLES = 750000,
   parameter int CLEAR_CYCLES   = 82000,
   parameter int REFRESH_CYCLES = 2500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH:0]   sum,
   output logic             busy,
   output logic             done,
   output logic             sf_e,
   output logic             lcd_e,
   output logic             lcd_rs,
   output logic             lcd_rw,
   output logic [3:0]       lcd_d
);

   localparam int          DIGITS     = digit_count(WIDTH + 1);
   localparam int          BCD_W      = 4 * DIGITS;
   localparam logic [31:0] PWR_LAST   = 32'(POWERUP_CYCLES - 1);
   localparam logic [31:0] CLR_LAST   = 32'(CLEAR_CYCLES - 1);
   localparam logic [31:0] CONV_LAST  = 32'(WIDTH);
   localparam logic [4:0]  WRITE_LAST = 5'(2 * DIGITS - 1);

   state_e           state_q, state_d;
   logic [31:0]      wait_q, wait_d;
   logic [4:0]       idx_q, idx_d;
   logic             pend_q, pend_d;
   logic [WIDTH:0]   sum_q, sum_d;
   logic [WIDTH:0]   sh_q, sh_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;

   logic             req;
   logic [WIDTH:0]   sum_new;
   logic [BCD_W-1:0] bcd_adj;
   logic [BCD_W+WIDTH:0] shift_v;
   logic [7:0]       cur_char;
   logic [7:0]       chr;
   logic [3:0]       dig;
   logic             lead;
   logic             sending;
   logic             seq_last;
   logic             tx_load, tx_rs, tx_ack;
   logic [3:0]       tx_nib;

`ifdef LCD_SUM_AUTO_REFRESH_EN
   localparam logic [31:0] REF_LAST = 32'(REFRESH_CYCLES - 1);
   logic [31:0] ref_q, ref_d;
   logic        ref_hit;

   always_ff @(posedge clk) begin
      if (rst) ref_q <= '0;
      else     ref_q <= ref_d;
   end

   // counts only while idle, so the period restarts on every entry to IDLE
   assign ref_hit = (state_q == ST_IDLE) && (ref_q == REF_LAST);
   assign req     = start || ref_hit;
   assign ref_d   = (state_q != ST_IDLE || req) ? 32'd0 : ref_q + 32'd1;
`else
   assign req = start;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_PWR_WAIT;
         wait_q  <= '0;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         sum_q   <= '0;
         sh_q    <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         sum_q   <= sum_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
      end
   end

   assign sum_new = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
      shift_v = {bcd_adj, sh_q} << 1;
   end

   // leading zeros blank, least significant digit always a numeral
   always_comb begin
      lead     = 1'b1;
      cur_char = ASCII_SPACE;
      chr      = ASCII_SPACE;
      dig      = 4'd0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         dig = bcd_q[4*k +: 4];
         if (lead && dig == 4'd0 && k != 0) begin
            chr = ASCII_SPACE;
         end else begin
            chr  = ASCII_ZERO + {4'd0, dig};
            lead = 1'b0;
         end
         if (k == DIGITS - 1 - int'(idx_q[4:1])) cur_char = chr;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      idx_d    = idx_q;
      pend_d   = pend_q;
      sum_d    = sum_q;
      sh_d     = sh_q;
      bcd_d    = bcd_q;
      tx_load  = 1'b0;
      tx_nib   = 4'h0;
      tx_rs    = 1'b0;
      done     = 1'b0;
      sending  = 1'b0;
      seq_last = 1'b0;
      case (state_q)
         ST_PWR_WAIT: begin
            if (wait_q == PWR_LAST) begin
               state_d = ST_INIT;
               wait_d  = '0;
               idx_d   = '0;
               pend_d  = 1'b0;
            end else begin
               wait_d = wait_q + 32'd1;
            end
         end
         ST_INIT: begin
            if (idx_q < 5'(INIT_NIBBLES)) begin
               sending  = 1'b1;
               tx_nib   = init_nibble(idx_q);
               seq_last = (idx_q == 5'(INIT_NIBBLES - 1));
            end else if (wait_q == CLR_LAST) begin
               state_d = ST_IDLE;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 32'd1;
            end
         end
         ST_IDLE: begin
            if (req) begin
               sum_d   = sum_new;
               sh_d    = sum_new;
               bcd_d   = '0;
               wait_d  = '0;
               state_d = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            bcd_d = shift_v[BCD_W+WIDTH:WIDTH+1];
            sh_d  = shift_v[WIDTH:0];
            if (wait_q == CONV_LAST) begin
               state_d = ST_HOME;
               wait_d  = '0;
               idx_d   = '0;
               pend_d  = 1'b0;
            end else begin
               wait_d = wait_q + 32'd1;
            end
         end
         ST_HOME: begin
            sending  = 1'b1;
            tx_nib   = idx_q[0] ? CMD_HOME[3:0] : CMD_HOME[7:4];
            seq_last = (idx_q == 5'd1);
         end
         ST_WRITE: begin
            sending  = 1'b1;
            tx_rs    = 1'b1;
            tx_nib   = idx_q[0] ? cur_char[3:0] : cur_char[7:4];
            seq_last = (idx_q == WRITE_LAST);
         end
         default: state_d = ST_PWR_WAIT;
      endcase

      // one nibble in flight at a time; the next load waits for ack
      if (sending) begin
         if (!pend_q) begin
            tx_load = 1'b1;
            pend_d  = 1'b1;
         end
         if (tx_ack) begin
            pend_d = 1'b0;
            idx_d  = idx_q + 5'd1;
            if (seq_last) begin
               case (state_q)
                  ST_INIT: wait_d = '0;
                  ST_HOME: begin
                     state_d = ST_WRITE;
                     idx_d   = '0;
                  end
                  ST_WRITE: begin
                     state_d = ST_IDLE;
                     idx_d   = '0;
                     done    = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   lcd_nibble_tx #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_tx (
      .clk   (clk),
      .rst   (rst),
      .load  (tx_load),
      .nib   (tx_nib),
      .rs    (tx_rs),
      .ack   (tx_ack),
      .lcd_e (lcd_e),
      .lcd_d (lcd_d),
      .lcd_rs(lcd_rs)
   );

   assign sum    = sum_q;
   assign busy   = (state_q != ST_IDLE);
   assign sf_e   = 1'b1;
   assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_sum_display.sv
// Scoreboard bench for lcd_sum_display: expected LCD nibbles are queued by the
// stimulus and popped by a monitor on every rising lcd_e.
module tb_lcd_sum_display;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic       cin = 1'b0;
   logic [4:0] sum;
   logic       busy, done, sf_e, lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_d;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   lcd_sum_display #(
      .WIDTH(4),
      .STEP_CYCLES(2),
      .POWERUP_CYCLES(20),
      .CLEAR_CYCLES(10),
      .REFRESH_CYCLES(100)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .sum(sum), .busy(busy), .done(done), .sf_e(sf_e), .lcd_e(lcd_e),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_nib(input logic rs_v, input logic [3:0] n);
      exp_q.push_back({rs_v, n});
   endtask

   task automatic push_byte(input logic rs_v, input logic [7:0] v);
      push_nib(rs_v, v[7:4]);
      push_nib(rs_v, v[3:0]);
   endtask

   task automatic push_init();
      push_nib(1'b0, 4'h3);
      push_nib(1'b0, 4'h3);
      push_nib(1'b0, 4'h3);
      push_nib(1'b0, 4'h2);
      push_byte(1'b0, 8'h28);
      push_byte(1'b0, 8'h06);
      push_byte(1'b0, 8'h0C);
      push_byte(1'b0, 8'h01);
   endtask

   task automatic monitor();
      logic prev_e;
      logic done_prev;
      logic [4:0] e;
      prev_e = 1'b0;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (lcd_e && !prev_e) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_nibble: got rs=%0d d=%0h expected none", lcd_rs, lcd_d);
            end else begin
               e = exp_q.pop_front();
               chk("nibble", int'({lcd_rs, lcd_d}), int'(e));
               chk("sf_e_rw", int'({sf_e, lcd_rw}), 2);
            end
         end
         if (done_prev) chk("busy_after_done", int'(busy), 0);
         if (done) begin
            done_cnt++;
            chk("busy_at_done", int'(busy), 1);
         end
         done_prev = done;
         prev_e = lcd_e;
      end
   endtask

   task automatic wait_idle(input string name, input int max);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      chk(name, int'(ok), 1);
   endtask

   task automatic wait_write_pulse(input string name, input int max);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (lcd_e && lcd_rs) ok = 1'b1;
      end
      chk(name, int'(ok), 1);
   endtask

   task automatic run_sum(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                          input int exp_sum, input logic [7:0] c1, input logic [7:0] c0,
                          input bit second_start);
      int d0;
      d0 = done_cnt;
      push_byte(1'b0, 8'h80);
      push_byte(1'b1, c1);
      push_byte(1'b1, c0);
      @(negedge clk);
      a = av; b = bv; cin = cv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~av; b = ~bv; cin = ~cv;
      chk("sum_next_cycle", int'(sum), exp_sum);
      chk("busy_accept", int'(busy), 1);
      if (second_start) begin
         wait_write_pulse("reach_write", 500);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle("redraw_done", 1000);
      repeat (30) @(negedge clk);
      chk("done_pulses", done_cnt - d0, 1);
      chk("queue_drained", exp_q.size(), 0);
      chk("sum_held", int'(sum), exp_sum);
   endtask

   initial begin
      int d0;
      fork
         monitor();
      join_none

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_lcd_e", int'(lcd_e), 0);
      chk("rst_lcd_rs", int'(lcd_rs), 0);
      chk("rst_lcd_d", int'(lcd_d), 0);
      chk("rst_sum", int'(sum), 0);
      chk("rst_sf_e", int'(sf_e), 1);
      chk("rst_lcd_rw", int'(lcd_rw), 0);

      push_init();
      rst = 1'b0;
      wait_idle("init_done", 2000);
      chk("init_drained", exp_q.size(), 0);

      run_sum(4'd15, 4'd15, 1'b1, 31, 8'h33, 8'h31, 1'b0);
      run_sum(4'd3, 4'd2, 1'b0, 5, 8'h20, 8'h35, 1'b0);
      run_sum(4'd0, 4'd0, 1'b0, 0, 8'h20, 8'h30, 1'b1);

      // reset in the middle of a WRITE enable pulse
      d0 = done_cnt;
      push_byte(1'b0, 8'h80);
      push_byte(1'b1, 8'h20);
      push_byte(1'b1, 8'h35);
      @(negedge clk);
      a = 4'd3; b = 4'd2; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_write_pulse("reach_write_rst", 500);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_lcd_e", int'(lcd_e), 0);
      chk("rst_mid_busy", int'(busy), 1);
      chk("rst_mid_sum", int'(sum), 0);
      exp_q.delete();
      push_init();
      @(negedge clk);
      rst = 1'b0;
      wait_idle("reinit_done", 2000);
      chk("reinit_drained", exp_q.size(), 0);
      chk("abort_no_done", done_cnt - d0, 0);

      d0 = done_cnt;
`ifdef LCD_SUM_AUTO_REFRESH_EN
      push_byte(1'b0, 8'h80);
      push_byte(1'b1, 8'h20);
      push_byte(1'b1, 8'h30);
      for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk("refresh_done", done_cnt - d0, 1);
      chk("refresh_drained", exp_q.size(), 0);
`else
      repeat (250) @(negedge clk);
      chk("no_refresh", done_cnt - d0, 0);
      chk("no_refresh_idle", int'(busy), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
